// File: rtl/counterupdown_nch_sync_reset.sv
`default_nettype none
// ============================================================================
// Module   : counterupdown_nch_sync_reset
// Brief    : Bank of NUM_CH independent up/down counters with wrap/saturate
//            boundary, terminal-count pulse, sticky overflow and coherent
//            snapshot capture.
// Revision : 1.0 - initial release
// ============================================================================
module counterupdown_nch_sync_reset #(
    parameter int WIDTH    = 16,
    parameter int NUM_CH   = 7,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH-1:0]         up_down,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH*WIDTH-1:0]   load_value,
    input  logic [NUM_CH-1:0]         clear,
    input  logic                      snap,
    output logic [NUM_CH*WIDTH-1:0]   count,
    output logic [NUM_CH-1:0]         tc,
    output logic [NUM_CH-1:0]         ovf,
    output logic [NUM_CH*WIDTH-1:0]   snapshot,
    output logic                      snap_valid
);

    localparam logic [WIDTH-1:0] C_MAX  = '1;
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam bit               C_SAT  = (SATURATE != 0);

    logic [NUM_CH*WIDTH-1:0] r_snapshot;
    logic                    r_snap_valid;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [WIDTH-1:0] r_count;
        logic             r_tc;
        logic             r_ovf;
        logic             w_at_max;
        logic             w_at_min;

        assign w_at_max = (r_count == C_MAX);
        assign w_at_min = (r_count == C_ZERO);

        always_ff @(posedge clk) begin
            if (reset || clear[gi]) begin
                r_count <= C_ZERO;
                r_tc    <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (load[gi]) begin
                r_count <= load_value[gi*WIDTH +: WIDTH];
                r_tc    <= 1'b0;
            end else if (en[gi]) begin
                if (up_down[gi]) begin
                    if (w_at_max) begin
                        r_count <= C_SAT ? C_MAX : C_ZERO;
                        r_tc    <= 1'b1;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                        r_tc    <= 1'b0;
                    end
                end else begin
                    if (w_at_min) begin
                        r_count <= C_SAT ? C_ZERO : C_MAX;
                        r_tc    <= 1'b1;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                        r_tc    <= 1'b0;
                    end
                end
            end else begin
                r_tc <= 1'b0;
            end
        end

        assign count[gi*WIDTH +: WIDTH] = r_count;
        assign tc[gi]                   = r_tc;
        assign ovf[gi]                  = r_ovf;
    end

    // Captures the pre-update counts of every channel on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snapshot   <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= snap;
            if (snap) begin
                r_snapshot <= count;
            end
        end
    end

    assign snapshot   = r_snapshot;
    assign snap_valid = r_snap_valid;

endmodule
`default_nettype wire

// File: tb/tb_counterupdown_nch_sync_reset.sv
`default_nettype none
// ============================================================================
// Module   : tb_counterupdown_nch_sync_reset
// Brief    : Self-checking bench; wrap and saturate instances against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counterupdown_nch_sync_reset;

    localparam int W    = 4;
    localparam int NCH  = 2;
    localparam int MAXV = (1 << W) - 1;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] en, up_down, load, clear;
    logic [NCH*W-1:0] load_value;
    logic           snap;

    logic [NCH*W-1:0] cnt_w, snp_w, cnt_s, snp_s;
    logic [NCH-1:0]   tc_w, ovf_w, tc_s, ovf_s;
    logic             sv_w, sv_s;

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    // model state: [instance 0 = wrap, 1 = saturate][channel]
    int m_cnt  [2][NCH];
    bit m_tc   [2][NCH];
    bit m_ovf  [2][NCH];
    int m_snap [2][NCH];
    bit m_sv   [2];

    counterupdown_nch_sync_reset #(.WIDTH(W), .NUM_CH(NCH), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_value(load_value), .clear(clear), .snap(snap),
        .count(cnt_w), .tc(tc_w), .ovf(ovf_w), .snapshot(snp_w), .snap_valid(sv_w)
    );

    counterupdown_nch_sync_reset #(.WIDTH(W), .NUM_CH(NCH), .SATURATE(1)) u_dut_sat (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_value(load_value), .clear(clear), .snap(snap),
        .count(cnt_s), .tc(tc_s), .ovf(ovf_s), .snapshot(snp_s), .snap_valid(sv_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: signed arithmetic step, out-of-range result means boundary hit.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                m_sv[s] = 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    m_cnt[s][c] = 0; m_tc[s][c] = 0; m_ovf[s][c] = 0; m_snap[s][c] = 0;
                end
            end else begin
                m_sv[s] = snap;
                for (int c = 0; c < NCH; c++) begin
                    int nxt;
                    if (snap) m_snap[s][c] = m_cnt[s][c];
                    if (clear[c]) begin
                        m_cnt[s][c] = 0; m_tc[s][c] = 0; m_ovf[s][c] = 0;
                    end else if (load[c]) begin
                        m_cnt[s][c] = int'(load_value[c*W +: W]); m_tc[s][c] = 0;
                    end else if (en[c]) begin
                        nxt = m_cnt[s][c] + (up_down[c] ? 1 : -1);
                        if (nxt < 0 || nxt > MAXV) begin
                            m_tc[s][c]  = 1;
                            m_ovf[s][c] = 1;
                            if (s == 0) m_cnt[s][c] = nxt & MAXV;
                        end else begin
                            m_cnt[s][c] = nxt;
                            m_tc[s][c]  = 0;
                        end
                    end else begin
                        m_tc[s][c] = 0;
                    end
                end
            end
        end
    end

    // Compare process: every output of both instances, every cycle after reset.
    always @(negedge clk) begin
        if (armed) begin
            for (int s = 0; s < 2; s++) begin
                logic [NCH*W-1:0] e_cnt, e_snp;
                logic [NCH-1:0]   e_tc, e_ovf;
                for (int c = 0; c < NCH; c++) begin
                    e_cnt[c*W +: W] = m_cnt[s][c][W-1:0];
                    e_snp[c*W +: W] = m_snap[s][c][W-1:0];
                    e_tc[c]         = m_tc[s][c];
                    e_ovf[c]        = m_ovf[s][c];
                end
                chk($sformatf("model_count_s%0d", s),    s ? cnt_s : cnt_w, e_cnt);
                chk($sformatf("model_tc_s%0d", s),       s ? tc_s  : tc_w,  e_tc);
                chk($sformatf("model_ovf_s%0d", s),      s ? ovf_s : ovf_w, e_ovf);
                chk($sformatf("model_snapshot_s%0d", s), s ? snp_s : snp_w, e_snp);
                chk($sformatf("model_snapvalid_s%0d", s), s ? sv_s : sv_w,  m_sv[s]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = '0; up_down = '0; load = '0; clear = '0;
        load_value = '0; snap = 1'b0;
        tick(); tick();
        armed = 1'b1;
        chk("reset_count_w", cnt_w, 0);
        chk("reset_snapvalid_s", sv_s, 0);

        // ch0 counts up through the boundary
        reset = 1'b0; en = 2'b01; up_down = 2'b01;
        repeat (15) tick();
        chk("up_ch0_15", cnt_w[3:0], 15);
        tick();
        chk("wrap_ch0_0", cnt_w[3:0], 0);
        chk("wrap_tc0", tc_w[0], 1);
        chk("wrap_ovf0", ovf_w[0], 1);
        chk("sat_hold_15", cnt_s[3:0], 15);
        tick();
        chk("wrap_ch0_1", cnt_w[3:0], 1);
        chk("wrap_tc0_low", tc_w[0], 0);
        chk("ch1_idle", cnt_w[7:4], 0);
        chk("sat_tc_held", tc_s[0], 1);
        up_down = 2'b00;
        tick();
        chk("sat_down_14", cnt_s[3:0], 14);
        chk("sat_down_tc", tc_s[0], 0);
        chk("sat_ovf_sticky", ovf_s[0], 1);

        // ch1 counts down from zero
        en = '0; clear = 2'b11;
        tick();
        clear = '0;
        chk("clear_ovf", ovf_w, 0);
        en = 2'b10; up_down = 2'b00;
        tick();
        chk("down_ch1_15", cnt_w[7:4], 15);
        chk("down_tc1", tc_w[1], 1);
        chk("sat_down_hold0", cnt_s[7:4], 0);
        tick(); tick();
        chk("down_ch1_13", cnt_w[7:4], 13);
        en = '0; clear = 2'b10;
        tick();
        clear = '0;
        chk("clear_ch1_cnt", cnt_w[7:4], 0);
        chk("clear_ch1_ovf", ovf_w[1], 0);
        chk("clear_ch1_tc", tc_w[1], 0);

        // priority clear > load > en
        clear = 2'b01; load = 2'b01; load_value = 8'h09; en = 2'b01; up_down = 2'b01;
        tick();
        chk("prio_clear", cnt_w[3:0], 0);
        clear = '0;
        tick();
        chk("prio_load", cnt_w[3:0], 9);

        // coherent snapshot
        load = 2'b11; load_value = 8'hA5; en = '0;
        tick();
        load = '0; en = 2'b11; up_down = 2'b11; snap = 1'b1;
        tick();
        chk("snap_value", snp_w, 8'hA5);
        chk("snap_valid", sv_w, 1);
        chk("snap_count", cnt_w, 8'hB6);
        snap = 1'b0;
        tick();
        chk("snap_valid_drop", sv_w, 0);
        chk("snap_hold", snp_w, 8'hA5);
        snap = 1'b1;
        tick(); tick();
        chk("snap_b2b_valid", sv_w, 1);
        chk("snap_b2b_value", snp_w, 8'hD8);
        snap = 1'b0;

        // loading the boundary value with en high
        load = 2'b01; load_value = 8'h0F; en = 2'b01; up_down = 2'b01;
        tick();
        chk("load_max_cnt", cnt_w[3:0], 15);
        chk("load_max_tc", tc_w[0], 0);
        chk("load_max_ovf", ovf_w[0], 0);
        load = '0;
        tick();
        chk("after_load_wrap", cnt_w[3:0], 0);
        chk("after_load_tc", tc_w[0], 1);

        // pseudo-random traffic checked by the model
        for (int k = 0; k < 60; k++) begin
            en         = NCH'($urandom);
            up_down    = NCH'($urandom);
            load       = NCH'(($urandom_range(0, 7) == 0) ? $urandom : 0);
            clear      = NCH'(($urandom_range(0, 11) == 0) ? $urandom : 0);
            load_value = (NCH*W)'($urandom);
            snap       = 1'($urandom);
            tick();
        end

        // reset mid-operation together with snap
        load = 2'b11; load_value = 8'hF3; en = '0; snap = 1'b0; clear = '0;
        tick();
        load = '0; en = 2'b11; up_down = 2'b11;
        tick();
        chk("pre_reset_ovf", ovf_w[1], 1);
        reset = 1'b1; snap = 1'b1;
        tick();
        chk("rst_count_w", cnt_w, 0);
        chk("rst_count_s", cnt_s, 0);
        chk("rst_ovf", ovf_w, 0);
        chk("rst_tc", tc_s, 0);
        chk("rst_snapshot", snp_w, 0);
        chk("rst_snapvalid", sv_w, 0);
        reset = 1'b0; snap = 1'b0; en = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counterupdown_nch_sync_reset.md
# counterupdown_nch_sync_reset

Parametrised bank of NUM_CH independent up/down counters sharing one clock, with per-channel enable, direction, load and clear. Each channel has a selectable wrap/saturate boundary mode, a terminal-count pulse and a sticky overflow flag. A snapshot port captures all channels coherently on the same edge. The bank is the single-clock, generalised successor to the fixed 16-bit up-counter arrays in the simple_registers/counters set, and it serves as a benchmark for multi-channel register banks.

## Interface
Parameters:
- WIDTH, 16, counter width per channel (>=2)
- NUM_CH, 7, number of channels (>=1)
- SATURATE, 0, 0 = wrap at boundary, 1 = hold at boundary

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- en  input  NUM_CH  per-channel count enable
- up_down  input  NUM_CH  per-channel direction: 1 = up, 0 = down
- load  input  NUM_CH  per-channel synchronous load strobe
- load_value  input  NUM_CH*WIDTH  load data; channel i occupies bits [i*WIDTH +: WIDTH]
- clear  input  NUM_CH  per-channel synchronous clear of count and ovf
- snap  input  1  capture all counts into snapshot
- count  output  NUM_CH*WIDTH  registered count values, same packing as load_value
- tc  output  NUM_CH  registered terminal-count pulse per channel
- ovf  output  NUM_CH  sticky boundary-hit flag per channel
- snapshot  output  NUM_CH*WIDTH  captured counts
- snap_valid  output  1  one-cycle pulse when snapshot has been updated

## Operation
- Reset values: count = 0, tc = 0, ovf = 0, snapshot = 0, snap_valid = 0.
- Reset has priority over every other input.
- Per-channel priority each edge: reset > clear[i] > load[i] > en[i] > hold.
- clear[i]: count_i <= 0, ovf[i] <= 0, tc[i] <= 0.
- load[i]: count_i <= load_value_i, tc[i] <= 0. ovf[i] is unchanged.
- en[i] with up_down[i]=1:
  - If count_i != 2^WIDTH-1: count_i + 1.
  - At 2^WIDTH-1: boundary hit. count_i becomes 0 when SATURATE=0 and stays at 2^WIDTH-1 when SATURATE=1.
- en[i] with up_down[i]=0:
  - If count_i != 0: count_i - 1.
  - At 0: boundary hit. count_i becomes 2^WIDTH-1 when SATURATE=0 and stays at 0 when SATURATE=1.
- Boundary hit: tc[i] <= 1 and ovf[i] <= 1 on the same edge. In every other case tc[i] <= 0.
- ovf[i] stays set until clear[i] or reset.
- Channels are fully independent. Arithmetic is modulo 2^WIDTH with no carry between channels.
- snap: snapshot <= count as it was before this edge's update, i.e. the values visible in the snap cycle. snap_valid <= 1. Otherwise snap_valid <= 0 and snapshot holds.
- Snapshot capture is coherent: all channels are captured on the same edge.

## Timing
- Count latency: 1 cycle. An input sampled at edge k is reflected on count, tc and ovf after edge k.
- tc is high for exactly the cycle after each boundary-hit edge.
- In saturate mode with en held at the boundary, tc stays high every cycle.
- Snapshot latency: 1 cycle. snap high in cycle k gives snapshot and snap_valid valid in cycle k+1, holding the count values from cycle k.
- snap and an update in the same cycle: snapshot gets the pre-update value, and count advances normally.
- Back-to-back snap: snapshot refreshes and snap_valid stays high every cycle.
- Reset asserted mid-count: all outputs read 0 in the cycle after the reset edge, including a pending snap_valid.
- Loading the boundary value with en also high: load wins, and no tc or ovf that cycle.

## Test plan
- WIDTH=4, NUM_CH=2, SATURATE=0. Channel 0: en=1, up_down=1 for 17 cycles -> count0 = 0..15, 0, 1. tc[0] is high only in the cycle count0 shows 0 after 15. ovf[0] = 1 from then on. Channel 1 (en=0) stays 0.
- SATURATE=0, channel 1 down from reset: en=1, up_down=0 -> count1 = 15, tc[1] = 1, then 14, 13. Assert clear[1] -> count1 = 0, ovf[1] = 0, tc[1] = 0 next cycle.
- SATURATE=1, up count: ch0 counts up to 15 and holds. tc[0] = 1 every cycle en stays high at 15. Switch up_down=0 -> 14, tc[0] = 0, ovf[0] remains 1.
- Priority: same cycle clear[0]=1, load[0]=1 (value 9), en[0]=1 -> count0 = 0. Next cycle load[0]=1, en[0]=1 -> count0 = 9, no increment.
- Snapshot coherence: ch0 = 5 and ch1 = 10, both counting up. Pulse snap -> next cycle snapshot = {10,5}, snap_valid = 1, count = {11,6}. The following cycle snap_valid = 0 and snapshot holds.
- Reset mid-operation: counts nonzero, ovf set, snap asserted together with reset -> next cycle all outputs 0 and snap_valid = 0.
